// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file.
//   AWIDTH_DEF / DWIDTH_DEF : default address and data widths
//   addr_t / data_t         : default-width address and data types
//   ZERO_ADDR               : address of the hardwired-zero register
package regfile_pkg;
   localparam int AWIDTH_DEF = 6;
   localparam int DWIDTH_DEF = 32;

   typedef logic [AWIDTH_DEF-1:0] addr_t;
   typedef logic [DWIDTH_DEF-1:0] data_t;

   localparam addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for multi-cycle producers.
//   clk, rst_n       : clock, async active-low reset
//   rsv_en, rsv_addr : reserve request (sets busy at the edge)
//   we, wa           : writeback ports (clear busy at the edge)
//   busy             : busy bit per register
//   busy_cnt         : registered population count of busy
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int AWIDTH   = AWIDTH_DEF,
   parameter int NWRITE   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           rsv_en,
   input  logic [AWIDTH-1:0]              rsv_addr,
   input  logic [NWRITE-1:0]              we,
   input  logic [NWRITE-1:0][AWIDTH-1:0]  wa,
   output logic [2**AWIDTH-1:0]           busy,
   output logic [AWIDTH:0]                busy_cnt
);
   localparam int NREG = 2**AWIDTH;
   localparam int CW   = AWIDTH + 1;
   localparam logic [AWIDTH-1:0] ZA = AWIDTH'(ZERO_ADDR);

   logic [NREG-1:0] set_v, clr_v, drop_v, busy_nxt;
   logic            inc;
   logic [CW-1:0]   dec;

   always_comb begin
      set_v = '0;
      clr_v = '0;
      if (rsv_en && !((ZERO_REG != 0) && (rsv_addr == ZA)))
         set_v[rsv_addr] = 1'b1;
      for (int j = 0; j < NWRITE; j++)
         if (we[j]) clr_v[wa[j]] = 1'b1;
   end

   // reservation beats a same-edge write, so only bits that are busy and
   // not re-reserved actually drop; duplicate write addresses count once
   assign drop_v   = busy & clr_v & ~set_v;
   assign inc      = |(set_v & ~busy);
   assign busy_nxt = (busy & ~clr_v) | set_v;

   always_comb begin
      dec = '0;
      for (int r = 0; r < NREG; r++)
         dec = dec + CW'(drop_v[r]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= busy_cnt + CW'(inc) - dec;
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: N-read / M-write register file with optional write-to-read
// bypass, optional hardwired-zero r0 and a busy scoreboard.
//   clk, rst_n        : clock, async active-low reset
//   ra / rd / rd_busy : combinational read ports (address, data, busy)
//   we / wa / wd      : write ports, highest index wins on address clash
//   rsv_en / rsv_addr : scoreboard reservation
//   busy_cnt          : number of busy registers (registered)
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int AWIDTH   = AWIDTH_DEF,
   parameter int DWIDTH   = DWIDTH_DEF,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREAD-1:0][AWIDTH-1:0]   ra,
   output logic [NREAD-1:0][DWIDTH-1:0]   rd,
   output logic [NREAD-1:0]               rd_busy,
   input  logic [NWRITE-1:0]              we,
   input  logic [NWRITE-1:0][AWIDTH-1:0]  wa,
   input  logic [NWRITE-1:0][DWIDTH-1:0]  wd,
   input  logic                           rsv_en,
   input  logic [AWIDTH-1:0]              rsv_addr,
   output logic [AWIDTH:0]                busy_cnt
);
   localparam int NREG = 2**AWIDTH;
   localparam logic [AWIDTH-1:0] ZA = AWIDTH'(ZERO_ADDR);

   logic [DWIDTH-1:0] mem [NREG];
   logic [NREG-1:0]   busy;

   // later ports overwrite earlier ones in the same edge: highest index wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) mem[r] <= '0;
      end else begin
         for (int j = 0; j < NWRITE; j++)
            if (we[j] && !((ZERO_REG != 0) && (wa[j] == ZA)))
               mem[wa[j]] <= wd[j];
      end
   end

   regfile_scoreboard #(
      .AWIDTH   (AWIDTH),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .we       (we),
      .wa       (wa),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic              hit, is_zero, busy_i;
      logic [DWIDTH-1:0] hit_d, rd_i;

      // ascending scan so the highest matching port is the one kept
      always_comb begin
         hit   = 1'b0;
         hit_d = '0;
         for (int j = 0; j < NWRITE; j++)
            if (we[j] && (wa[j] == ra[i])) begin
               hit   = 1'b1;
               hit_d = wd[j];
            end
      end

      assign is_zero = (ZERO_REG != 0) && (ra[i] == ZA);

      always_comb begin
         rd_i   = mem[ra[i]];
         busy_i = busy[ra[i]];
         if (is_zero) begin
            rd_i   = '0;
            busy_i = 1'b0;
         end else if ((BYPASS != 0) && hit) begin
            // the write about to land also retires the reservation
            rd_i   = hit_d;
            busy_i = 1'b0;
         end
      end

      assign rd[i]      = rd_i;
      assign rd_busy[i] = busy_i;
   end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus for the bypass (a) and no-bypass (b) instances
   logic [1:0][5:0]  ra;
   logic [1:0]       we;
   logic [1:0][5:0]  wa;
   logic [1:0][31:0] wd;
   logic             rsv_en;
   logic [5:0]       rsv_addr;
   logic [1:0][31:0] a_rd, b_rd;
   logic [1:0]       a_bz, b_bz;
   logic [6:0]       a_cnt, b_cnt;

   // small instance, AWIDTH=3
   logic [1:0][2:0]  c_ra;
   logic [1:0]       c_we;
   logic [1:0][2:0]  c_wa;
   logic [1:0][31:0] c_wd;
   logic             c_rsv_en;
   logic [2:0]       c_rsv_addr;
   logic [1:0][31:0] c_rd;
   logic [1:0]       c_bz;
   logic [3:0]       c_cnt;

   regfile_mp #(.BYPASS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(a_rd), .rd_busy(a_bz),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_cnt(a_cnt));

   regfile_mp #(.BYPASS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(b_rd), .rd_busy(b_bz),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_cnt(b_cnt));

   regfile_mp #(.AWIDTH(3), .ZERO_REG(1)) u_c (
      .clk(clk), .rst_n(rst_n), .ra(c_ra), .rd(c_rd), .rd_busy(c_bz),
      .we(c_we), .wa(c_wa), .wd(c_wd), .rsv_en(c_rsv_en),
      .rsv_addr(c_rsv_addr), .busy_cnt(c_cnt));

   string       tq[$];
   logic [63:0] vq[$];
   int n_pass = 0;
   int n_total = 0;

   task automatic ex(input string t, input logic [63:0] v);
      tq.push_back(t);
      vq.push_back(v);
   endtask

   task automatic pop_chk(input logic [63:0] obs);
      string t;
      logic [63:0] e;
      n_total++;
      if (vq.size() == 0) begin
         $error("FAIL sb_empty: observed %h expected <queued value>", obs);
         return;
      end
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", t, obs, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0; rsv_en = 1'b0; c_we = '0; c_rsv_en = 1'b0;
   endtask

   initial begin
      ra = '0; wa = '0; wd = '0; rsv_addr = '0;
      c_ra = '0; c_wa = '0; c_wd = '0; c_rsv_addr = '0;
      idle();
      #1 rst_n = 1'b0;
      #2;
      ex("rst_rd0", 0);   pop_chk(a_rd[0]);
      ex("rst_bz", 0);    pop_chk(a_bz);
      ex("rst_cnt", 0);   pop_chk(a_cnt);
      ex("rst_c_cnt", 0); pop_chk(c_cnt);
      @(posedge clk); #1 rst_n = 1'b1;

      // reset and zero register
      we = 2'b01; wa[0] = 6'd5; wd[0] = 32'hDEADBEEF;
      tick();
      wa[0] = 6'd0; rsv_en = 1'b1; rsv_addr = 6'd20;
      tick();
      idle(); ra[0] = 6'd5; ra[1] = 6'd0;
      ex("r5_written", 32'hDEADBEEF); ex("r0_zero", 0); ex("cnt_pre_rst", 1);
      #1;
      pop_chk(a_rd[0]); pop_chk(a_rd[1]); pop_chk(a_cnt);
      #1 rst_n = 1'b0;
      ex("r5_midrst", 0); ex("cnt_midrst", 0);
      #1;
      pop_chk(a_rd[0]); pop_chk(a_cnt);
      #1 rst_n = 1'b1;
      tick();
      we = 2'b01; wa[0] = 6'd0; wd[0] = 32'h1234;
      ex("r0_bypass_blk", 0);
      #1 pop_chk(a_rd[1]);
      tick(); idle();
      ex("r0_after_wr", 0);
      #1 pop_chk(a_rd[1]);

      // write priority
      we = 2'b11; wa[0] = 6'd7; wa[1] = 6'd7;
      wd[0] = 32'h11111111; wd[1] = 32'h22222222; ra[0] = 6'd7;
      ex("prio_byp_same", 32'h22222222); ex("prio_nobyp_same", 0);
      #1 pop_chk(a_rd[0]); pop_chk(b_rd[0]);
      tick(); idle();
      ex("prio_next_a", 32'h22222222); ex("prio_next_b", 32'h22222222);
      #1 pop_chk(a_rd[0]); pop_chk(b_rd[0]);

      // bypass off
      we = 2'b01; wa[0] = 6'd3; wd[0] = 32'hA5A5A5A5; ra[0] = 6'd3;
      ex("nobyp_old", 0); ex("byp_new", 32'hA5A5A5A5);
      #1 pop_chk(b_rd[0]); pop_chk(a_rd[0]);
      tick(); idle();
      ex("nobyp_next", 32'hA5A5A5A5);
      #1 pop_chk(b_rd[0]);

      // scoreboard basic
      rsv_en = 1'b1; rsv_addr = 6'd9; ra[0] = 6'd9;
      ex("rsv_no_comb", 0);
      #1 pop_chk(a_bz[0]);
      tick(); idle();
      ex("rsv_busy", 1); ex("rsv_cnt", 1);
      #1 pop_chk(a_bz[0]); pop_chk(a_cnt);
      we = 2'b01; wa[0] = 6'd9; wd[0] = 32'h9;
      ex("wr_clr_byp", 0); ex("wr_data_byp", 32'h9); ex("wr_busy_nobyp", 1);
      ex("wr_cnt_same", 1);
      #1 pop_chk(a_bz[0]); pop_chk(a_rd[0]); pop_chk(b_bz[0]); pop_chk(a_cnt);
      tick(); idle();
      ex("wr_cnt_next", 0); ex("wr_busy_next", 0);
      #1 pop_chk(a_cnt); pop_chk(a_bz[0]);

      // simultaneous reserve and write
      rsv_en = 1'b1; rsv_addr = 6'd4;
      tick();
      we = 2'b10; wa[1] = 6'd4; wd[1] = 32'h44;
      tick(); idle(); ra[0] = 6'd4; ra[1] = 6'd10;
      ex("rw_data", 32'h44); ex("rw_busy", 1); ex("rw_cnt", 1);
      #1 pop_chk(a_rd[0]); pop_chk(a_bz[0]); pop_chk(a_cnt);
      rsv_en = 1'b1; rsv_addr = 6'd10; we = 2'b01; wa[0] = 6'd4; wd[0] = 32'h55;
      tick(); idle();
      ex("swap_cnt", 1); ex("swap_r4_free", 0); ex("swap_r10_busy", 1);
      ex("swap_r4_data", 32'h55);
      #1 pop_chk(a_cnt); pop_chk(a_bz[0]); pop_chk(a_bz[1]); pop_chk(a_rd[0]);
      rsv_en = 1'b1; rsv_addr = 6'd10;
      tick(); idle();
      ex("rersv_cnt", 1); ex("rersv_cnt_b", 1);
      #1 pop_chk(a_cnt); pop_chk(b_cnt);

      // fill and drain on the small instance
      for (int r = 1; r < 8; r++) begin
         c_rsv_en = 1'b1; c_rsv_addr = 3'(r);
         tick();
      end
      idle();
      ex("fill_cnt", 7);
      #1 pop_chk(c_cnt);
      c_rsv_en = 1'b1; c_rsv_addr = 3'd0; c_ra[0] = 3'd0;
      tick(); idle();
      ex("rsv_r0_cnt", 7); ex("rsv_r0_bz", 0);
      #1 pop_chk(c_cnt); pop_chk(c_bz[0]);
      c_we = 2'b11; c_wa[0] = 3'd1; c_wa[1] = 3'd2; c_ra[0] = 3'd3; c_ra[1] = 3'd1;
      tick(); idle();
      ex("drain2_cnt", 5); ex("drain_r3_busy", 1); ex("drain_r1_free", 0);
      #1 pop_chk(c_cnt); pop_chk(c_bz[0]); pop_chk(c_bz[1]);
      c_we = 2'b11; c_wa[0] = 3'd3; c_wa[1] = 3'd3;
      tick(); idle();
      ex("dup_clr_cnt", 4);
      #1 pop_chk(c_cnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
